// File: rtl/zvc_pkg.sv
// Shared types and helpers for the zero-value compressor: default geometry,
// derived widths, the FSM state encoding and a population-count function.
package zvc_pkg;

    localparam int DEF_WORD_WIDTH    = 8;
    localparam int DEF_LINE_SIZE     = 128;
    localparam int DEF_DIST_WIDTH    = 7;
    localparam int DEF_MAX_LIFM_RSIZ = 4;
    localparam int DEF_CHUNK         = 16;

    localparam int MT_ENTRY_W = DEF_DIST_WIDTH * DEF_MAX_LIFM_RSIZ;
    localparam int CNT_W      = $clog2(DEF_LINE_SIZE + 1);

    // Widest vector popcount accepts; narrower callers zero-extend.
    localparam int POP_MAX_W  = 1024;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMPRESS = 2'd1,
        OUTPUT   = 2'd2
    } zvc_state_e;

    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/zvc_chunk_compactor.sv
// Combinational compaction of one chunk: non-zero words and their MT entries
// are packed to the low slots in index order, with a presence mask and count.
module zvc_chunk_compactor
    import zvc_pkg::*;
#(
    parameter int CHUNK      = 16,
    parameter int WORD_WIDTH = 8,
    parameter int MT_W       = 28,
    localparam int CCW       = $clog2(CHUNK + 1)
) (
    input  logic [CHUNK*WORD_WIDTH-1:0] words_i,
    input  logic [CHUNK*MT_W-1:0]       mt_i,
    output logic [CHUNK*WORD_WIDTH-1:0] words_o,
    output logic [CHUNK*MT_W-1:0]       mt_o,
    output logic [CHUNK-1:0]            mask_o,
    output logic [CCW-1:0]              cnt_o
);

    int pos;

    // pos is the running prefix sum of non-zero words seen so far, which is
    // exactly the destination slot of the next non-zero word.
    always_comb begin
        words_o = '0;
        mt_o    = '0;
        mask_o  = '0;
        pos     = 0;
        for (int i = 0; i < CHUNK; i++) begin
            if (words_i[i*WORD_WIDTH +: WORD_WIDTH] != '0) begin
                mask_o[i]                           = 1'b1;
                words_o[pos*WORD_WIDTH +: WORD_WIDTH] = words_i[i*WORD_WIDTH +: WORD_WIDTH];
                mt_o[pos*MT_W +: MT_W]              = mt_i[i*MT_W +: MT_W];
                pos                                 = pos + 1;
            end
        end
    end

    assign cnt_o = CCW'(popcount(POP_MAX_W'(mask_o)));

endmodule

// File: rtl/zvc_compressor_seq.sv
// Multi-cycle zero-value compressor: captures a LIFM/MT line, compacts it
// CHUNK words per cycle into an output buffer and presents the result.
module zvc_compressor_seq
    import zvc_pkg::*;
#(
    parameter int WORD_WIDTH    = DEF_WORD_WIDTH,
    parameter int LINE_SIZE     = DEF_LINE_SIZE,
    parameter int DIST_WIDTH    = DEF_DIST_WIDTH,
    parameter int MAX_LIFM_RSIZ = DEF_MAX_LIFM_RSIZ,
    parameter int CHUNK         = DEF_CHUNK
) (
    input  logic                                            clk,
    input  logic                                            reset_n,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    input  logic                                            bypass,
    input  logic [LINE_SIZE*WORD_WIDTH-1:0]                 lifm_line,
    input  logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0]   mt_line,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [LINE_SIZE*WORD_WIDTH-1:0]                 lifm_comp,
    output logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0]   mt_comp,
    output logic [LINE_SIZE-1:0]                            nz_mask,
    output logic [$clog2(LINE_SIZE+1)-1:0]                  nz_cnt
);

    localparam int MT_W  = DIST_WIDTH * MAX_LIFM_RSIZ;
    localparam int CW    = $clog2(LINE_SIZE + 1);
    localparam int N     = LINE_SIZE / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CCW   = $clog2(CHUNK + 1);

    zvc_state_e                   state_q;
    logic                         in_ready_q, out_valid_q, bypass_q;
    logic [IDX_W-1:0]             chunk_q;
    logic [LINE_SIZE*WORD_WIDTH-1:0] lifm_q, comp_q, comp_d;
    logic [LINE_SIZE*MT_W-1:0]    mt_q, mtc_q, mtc_d;
    logic [LINE_SIZE-1:0]         mask_q, mask_d;
    logic [CW-1:0]                cnt_q, cnt_d;

    logic [CHUNK*WORD_WIDTH-1:0]  cc_words;
    logic [CHUNK*MT_W-1:0]        cc_mt;
    logic [CHUNK-1:0]             cc_mask;
    logic [CCW-1:0]               cc_cnt;

    zvc_chunk_compactor #(
        .CHUNK      (CHUNK),
        .WORD_WIDTH (WORD_WIDTH),
        .MT_W       (MT_W)
    ) u_chunk (
        .words_i (lifm_q[int'(chunk_q)*CHUNK*WORD_WIDTH +: CHUNK*WORD_WIDTH]),
        .mt_i    (mt_q[int'(chunk_q)*CHUNK*MT_W +: CHUNK*MT_W]),
        .words_o (cc_words),
        .mt_o    (cc_mt),
        .mask_o  (cc_mask),
        .cnt_o   (cc_cnt)
    );

    // Append the compacted chunk at the write pointer (cnt_q). Only the first
    // cc_cnt slots are written, so wp+j always stays inside the line.
    always_comb begin
        comp_d = comp_q;
        mtc_d  = mtc_q;
        mask_d = mask_q;
        mask_d[int'(chunk_q)*CHUNK +: CHUNK] = cc_mask;
        cnt_d  = cnt_q + CW'(cc_cnt);
        for (int j = 0; j < CHUNK; j++) begin
            if (j < int'(cc_cnt)) begin
                comp_d[(int'(cnt_q)+j)*WORD_WIDTH +: WORD_WIDTH] = cc_words[j*WORD_WIDTH +: WORD_WIDTH];
                mtc_d[(int'(cnt_q)+j)*MT_W +: MT_W]              = cc_mt[j*MT_W +: MT_W];
            end
        end
    end

    // Bypass lines enter OUTPUT with out_valid low and load the captured line
    // on the following edge, giving one cycle of latency like a one-chunk line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            bypass_q    <= 1'b0;
            chunk_q     <= '0;
            lifm_q      <= '0;
            mt_q        <= '0;
            comp_q      <= '0;
            mtc_q       <= '0;
            mask_q      <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        lifm_q     <= lifm_line;
                        mt_q       <= mt_line;
                        bypass_q   <= bypass;
                        comp_q     <= '0;
                        mtc_q      <= '0;
                        mask_q     <= '0;
                        cnt_q      <= '0;
                        chunk_q    <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= bypass ? OUTPUT : COMPRESS;
                    end
                end
                COMPRESS: begin
                    comp_q <= comp_d;
                    mtc_q  <= mtc_d;
                    mask_q <= mask_d;
                    cnt_q  <= cnt_d;
                    if (chunk_q == IDX_W'(N - 1)) begin
                        out_valid_q <= 1'b1;
                        state_q     <= OUTPUT;
                    end else begin
                        chunk_q <= chunk_q + 1'b1;
                    end
                end
                OUTPUT: begin
                    if (!out_valid_q) begin
                        if (bypass_q) begin
                            comp_q <= lifm_q;
                            mtc_q  <= mt_q;
                            mask_q <= '1;
                            cnt_q  <= CW'(LINE_SIZE);
                        end
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign lifm_comp = comp_q;
    assign mt_comp   = mtc_q;
    assign nz_mask   = mask_q;
    assign nz_cnt    = cnt_q;

endmodule
